// File: rtl/line_window_pkg.sv
// Shared constants and helpers for the line window buffer.
package line_window_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int ADDR_W_DEF = 11;
  localparam int LINES_DEF  = 2;
  localparam int LINES_MIN  = 1;
  localparam int LINES_MAX  = 8;

  // Clamp a requested line length to [2, max_len]. The lower bound keeps the
  // column read and the pending write on different addresses in any cycle.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    if (len < 2) begin
      return 2;
    end else if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/line_window_buffer_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port with enable.
module sdp_ram
  import line_window_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Write and registered read; read data holds while re_i is low.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/line_window_buffer.sv
// Multi-line pixel buffer: stores LINES previous rows and emits one vertical
// column of LINES+1 pixels per accepted input pixel, with 1-cycle latency.
module line_window_buffer
  import line_window_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINES  = LINES_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W:0]           line_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_sof,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [(LINES+1)*DATA_W-1:0] out_col,
  output logic [ADDR_W-1:0]         out_x,
  output logic                      out_eol,
  output logic                      out_sof,
  output logic                      out_primed
);

  localparam int Y_W = $clog2(LINES + 1);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  if (LINES < LINES_MIN || LINES > LINES_MAX) begin : g_bad_lines
    $error("line_window_buffer: LINES must be within 1..8");
  end

  logic              accept;
  logic [ADDR_W:0]   len_q, len_eff;
  logic [ADDR_W-1:0] x_q, x_cur, x_d;
  logic [Y_W-1:0]    y_q, y_cur, y_d;
  logic              eol_cur;

  logic              out_valid_q, out_eol_q, out_sof_q, out_primed_q;
  logic [ADDR_W-1:0] out_x_q;
  logic [DATA_W-1:0] pix_q;
  logic              col_live_q;
  logic              wr_pend_q;

  logic [DATA_W-1:0] rd_data [LINES];
  logic [DATA_W-1:0] wr_data [LINES];

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Position of the incoming pixel; an accepted sof restarts at (0,0) with a fresh length.
  always_comb begin
    len_eff = len_q;
    x_cur   = x_q;
    y_cur   = y_q;
    if (in_sof) begin
      len_eff = (ADDR_W+1)'(clamp_len(32'(line_len), 32'(MAX_LEN)));
      x_cur   = '0;
      y_cur   = '0;
    end
    eol_cur = ({1'b0, x_cur} == (len_eff - 1'b1));
    x_d     = eol_cur ? '0 : x_cur + 1'b1;
    y_d     = y_cur;
    if (eol_cur && (y_cur != Y_W'(LINES))) begin
      y_d = y_cur + 1'b1;
    end
  end

  // Column/row counters and line length latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= MAX_LEN;
      x_q   <= '0;
      y_q   <= '0;
    end else if (accept) begin
      x_q <= x_d;
      y_q <= y_d;
      if (in_sof) begin
        len_q <= len_eff;
      end
    end
  end

  // One-deep output stage; the pending-write flag lives exactly one cycle per accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_x_q      <= '0;
      out_eol_q    <= 1'b0;
      out_sof_q    <= 1'b0;
      out_primed_q <= 1'b0;
      pix_q        <= '0;
      col_live_q   <= 1'b0;
      wr_pend_q    <= 1'b0;
    end else begin
      wr_pend_q <= accept;
      if (accept) begin
        out_valid_q  <= 1'b1;
        out_x_q      <= x_cur;
        out_eol_q    <= eol_cur;
        out_sof_q    <= in_sof;
        out_primed_q <= (y_cur == Y_W'(LINES));
        pix_q        <= in_data;
        col_live_q   <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Row store: RAM0 takes the new pixel, RAM k takes what RAM k-1 held at that column.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_line
    if (gi == 0) begin : g_first
      assign wr_data[gi] = pix_q;
    end else begin : g_shift
      assign wr_data[gi] = rd_data[gi-1];
    end

    sdp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk     (clk),
      .we_i    (wr_pend_q),
      .waddr_i (out_x_q),
      .wdata_i (wr_data[gi]),
      .re_i    (accept),
      .raddr_i (x_cur),
      .rdata_o (rd_data[gi])
    );

    // The RAM read register is not reset, so keep the column at zero until real reads exist.
    assign out_col[(gi+1)*DATA_W +: DATA_W] = col_live_q ? rd_data[gi] : '0;
  end

  assign out_col[DATA_W-1:0] = pix_q;
  assign out_valid  = out_valid_q;
  assign out_x      = out_x_q;
  assign out_eol    = out_eol_q;
  assign out_sof    = out_sof_q;
  assign out_primed = out_primed_q;

endmodule
